// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of a UART transmitter: stores up to DEPTH bytes and
// launches them one at a time over a start/done handshake, abandoning a frame after TIMEOUT cycles.
module uart_tx_fifo #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_timer;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_busy;
  logic              r_timeout_err;

  logic              w_push;
  logic              w_pop;
  logic              w_timeout_hit;
  logic [ADDR_W:0]   w_count_nxt;

  // full is the registered flag, so a push in the same cycle as a launch from full is rejected
  assign w_push        = wr_en && !r_full;
  assign w_pop         = (r_state == S_IDLE) && !r_empty;
  assign w_timeout_hit = (r_timer == 8'(TIMEOUT - 1));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_overflow    <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_overflow    <= wr_en && r_full;
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
      r_empty       <= (w_count_nxt == '0);
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      case (r_state)
        S_IDLE: begin
          if (!r_empty) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_tx_start <= 1'b1;
            r_timer    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 8'd1;
          // done takes priority over a coincident timeout
          if (tx_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_timeout_hit) begin
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
